// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//   Shares one APB master port (8-bit address, 32-bit data) among NUM_REQ
//   local requesters with round-robin arbitration. Each accepted request is
//   run through the APB SETUP and ACCESS phases. The completion (read data
//   and error status) is returned to the requester that owned the transfer.
//   Back-to-back transfers re-arbitrate in the ACCESS cycle that sees pready,
//   so the bus goes straight from ACCESS to the next SETUP without an idle gap.
//
// Ports
//   pclk, preset_n          clock, synchronous active-low reset
//   req_valid/ready         per-requester handshake (ready is one-hot or zero)
//   req_write/addr/wdata    per-requester command, requester i in slice i
//   rsp_valid               one-cycle completion pulse to the owning requester
//   rsp_rdata, rsp_slverr   completion payload, valid with rsp_valid
//   psel..pwdata            APB master outputs
//   prdata, pready, pslverr APB slave responses
//
// State table
//   state     | meaning
//   ST_IDLE   | bus idle, arbitrating every cycle
//   ST_SETUP  | APB setup phase (psel=1, penable=0), lasts one cycle
//   ST_ACCESS | APB access phase (psel=1, penable=1), waiting for pready
module apb_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*8-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [7:0]            paddr,
  output logic [31:0]           pwdata,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [TMO_W-1:0]   TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] owner_q;
  logic [TMO_W-1:0] tmo_cnt_q;

  logic [IDX_W-1:0] winner;
  logic [IDX_W:0]   cand;
  logic             win_found;
  logic             arb_en;
  logic             accept;
  logic             timeout;
  logic             done;
  logic             sel_write;
  logic [7:0]       sel_addr;
  logic [31:0]      sel_wdata;

  // Round-robin search starting just after the last grant, with wrap-around.
  // cand carries one extra bit so last_grant + k never overflows before the
  // modulo correction.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        winner    = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*8 +: 8];
        sel_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

  // The down-counter is loaded on accept and reaches 1 on the last permitted
  // waited ACCESS cycle; a timeout ends the transfer without arbitrating.
  // Acceptance is gated by preset_n so no requester sees a handshake that the
  // reset edge would throw away.
  assign timeout = (TIMEOUT_CYCLES != 0) && (state_q == ST_ACCESS) && !pready &&
                   (tmo_cnt_q == TMO_W'(1));
  assign done    = (state_q == ST_ACCESS) && (pready || timeout);
  assign arb_en  = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && pready);
  assign accept  = preset_n && arb_en && win_found;

  assign req_ready = accept ? (ONE_HOT0 << winner) : '0;
  assign psel      = (state_q != ST_IDLE);
  assign penable   = (state_q == ST_ACCESS);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d = accept ? ST_SETUP : ST_IDLE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      tmo_cnt_q    <= '0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_slverr   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= '0;

      if (done) begin
        rsp_valid  <= ONE_HOT0 << owner_q;
        rsp_rdata  <= (timeout || pwrite) ? 32'h0 : prdata;
        rsp_slverr <= timeout | pslverr;
      end

      if (accept) begin
        last_grant_q <= winner;
        owner_q      <= winner;
        pwrite       <= sel_write;
        paddr        <= sel_addr;
        pwdata       <= sel_wdata;
        tmo_cnt_q    <= TMO_LOAD;
      end else if ((state_q == ST_ACCESS) && !pready && (tmo_cnt_q != '0)) begin
        tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Testbench for apb_master_arbiter: directed scenarios followed by a
// randomized run, all checked against a transaction-level reference model.
module tb_apb_master_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic              pclk = 1'b0;
  logic              preset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_write;
  logic [N*8-1:0]    req_addr;
  logic [N*32-1:0]   req_wdata;
  logic [N-1:0]      rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_slverr;
  logic              psel, penable, pwrite;
  logic [7:0]        paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  apb_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // requester-side pending commands
  logic        pend_v [N];
  logic        pend_w [N];
  logic [7:0]  pend_a [N];
  logic [31:0] pend_d [N];
  int          req_mode = 0;   // 0 directed, 1 keep all valid, 2 random

  // slave behaviour
  int          slv_mode  = 0;  // 0 fixed wait states, 1 random, 2 never ready
  int          slv_wait  = 0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          acc_cnt   = 0;
  logic        rst_drv   = 1'b0;

  // reference model: one outstanding transfer with its age since acceptance
  logic        m_busy;
  int          m_age, m_waits, m_last, m_owner;
  logic        m_pwrite;
  logic [7:0]  m_paddr;
  logic [31:0] m_pwdata;
  logic [N-1:0] m_rsp_valid;
  logic [31:0] m_rdata;
  logic        m_err;

  // observations for directed checks
  int          cyc = 0;
  int          n_psel, n_pen;
  logic [N-1:0] seen_mask;
  logic [31:0] seen_rdata;
  logic        seen_err;
  int          grant_q[$];
  int          grant_cyc[$];

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_waits = 0; m_last = N - 1; m_owner = 0;
    m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
    m_rsp_valid = '0; m_rdata = '0; m_err = 1'b0;
  endtask

  task automatic clr_obs();
    n_psel = 0; n_pen = 0; seen_mask = '0; seen_rdata = '0; seen_err = 1'b0;
    grant_q.delete(); grant_cyc.delete();
  endtask

  task automatic step();
    int      win;
    logic    allowed, tmo_now, done_now;
    logic [N-1:0] exp_ready;
    @(negedge pclk);
    // registered outputs reflect the previous edge
    chk("psel", 32'(psel), 32'(m_busy));
    chk("penable", 32'(penable), 32'(m_busy && m_age >= 1));
    chk("paddr", 32'(paddr), 32'(m_paddr));
    chk("pwrite", 32'(pwrite), 32'(m_pwrite));
    chk("pwdata", pwdata, m_pwdata);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    if (m_rsp_valid != '0) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_slverr", 32'(rsp_slverr), 32'(m_err));
    end
    if (psel) n_psel++;
    if (penable) n_pen++;
    if (rsp_valid != '0) begin
      seen_mask  = seen_mask | rsp_valid;
      seen_rdata = rsp_rdata;
      seen_err   = rsp_slverr;
    end

    // slave
    if (penable) acc_cnt++; else acc_cnt = 0;
    case (slv_mode)
      0: begin pready = (acc_cnt > slv_wait); prdata = slv_rdata; pslverr = slv_err; end
      1: begin
        pready  = ($urandom_range(0, 99) < 60);
        prdata  = $urandom;
        pslverr = ($urandom_range(0, 9) == 0);
      end
      default: begin pready = 1'b0; prdata = slv_rdata; pslverr = slv_err; end
    endcase

    // requesters
    for (int i = 0; i < N; i++) begin
      if ((req_mode == 1 && !pend_v[i]) ||
          (req_mode == 2 && !pend_v[i] && $urandom_range(0, 99) < 30)) begin
        pend_v[i] = 1'b1;
        pend_w[i] = 1'($urandom);
        pend_a[i] = 8'($urandom);
        pend_d[i] = $urandom;
      end else if (req_mode == 2 && pend_v[i] && $urandom_range(0, 99) < 3) begin
        pend_v[i] = 1'b0;
      end
      req_valid[i]          = pend_v[i];
      req_write[i]          = pend_w[i];
      req_addr[i*8 +: 8]    = pend_a[i];
      req_wdata[i*32 +: 32] = pend_d[i];
    end
    preset_n = rst_drv;
    #1;

    if (!rst_drv) begin
      model_reset();
    end else begin
      allowed  = !m_busy || (m_age >= 1 && pready);
      tmo_now  = m_busy && m_age >= 1 && !pready && (TMO > 0) && (m_waits + 1 == TMO);
      done_now = m_busy && m_age >= 1 && (pready || tmo_now);
      win = -1;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (win < 0 && req_valid[idx]) win = idx;
      end
      exp_ready = '0;
      if (allowed && win >= 0) exp_ready[win] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));

      m_rsp_valid = '0;
      if (done_now) begin
        m_rsp_valid[m_owner] = 1'b1;
        m_rdata = (tmo_now || m_pwrite) ? 32'h0 : prdata;
        m_err   = tmo_now ? 1'b1 : pslverr;
        m_busy  = 1'b0;
      end else if (m_busy) begin
        if (m_age >= 1) m_waits++;
        m_age++;
      end
      if (allowed && win >= 0) begin
        m_busy = 1'b1; m_age = 0; m_waits = 0; m_owner = win; m_last = win;
        m_pwrite = pend_w[win]; m_paddr = pend_a[win]; m_pwdata = pend_d[win];
        pend_v[win] = 1'b0;
        grant_q.push_back(win);
        grant_cyc.push_back(cyc);
      end
    end
    cyc++;
  endtask

  task automatic reset_dut();
    rst_drv = 1'b0;
    step();
    step();
    rst_drv = 1'b1;
  endtask

  task automatic run_until_rsp(input string tag, input int max_cyc);
    int n = 0;
    while (seen_mask == '0 && n < max_cyc) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 32'(seen_mask != '0), 32'd1);
  endtask

  task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [31:0] d);
    pend_v[i] = 1'b1; pend_w[i] = w; pend_a[i] = a; pend_d[i] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0; pend_w[i] = 1'b0; pend_a[i] = '0; pend_d[i] = '0;
    end
    preset_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(posedge pclk);
    model_reset();
    reset_dut();

    // single write, zero wait
    clr_obs();
    slv_mode = 0; slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h0;
    set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
    run_until_rsp("t1", 20);
    chk("t1_psel_cycles", 32'(n_psel), 32'd2);
    chk("t1_penable_cycles", 32'(n_pen), 32'd1);
    chk("t1_rsp_mask", 32'(seen_mask), 32'h1);
    chk("t1_slverr", 32'(seen_err), 32'd0);

    // read from requester 2 with 3 wait states
    reset_dut(); clr_obs();
    slv_wait = 3; slv_rdata = 32'h12345678;
    set_req(2, 1'b0, 8'h44, 32'h0);
    run_until_rsp("t2", 20);
    chk("t2_penable_cycles", 32'(n_pen), 32'd4);
    chk("t2_psel_cycles", 32'(n_psel), 32'd5);
    chk("t2_rdata", seen_rdata, 32'h12345678);
    chk("t2_rsp_mask", 32'(seen_mask), 32'h4);

    // round robin with all requesters held valid
    reset_dut(); clr_obs();
    slv_wait = 0; req_mode = 1;
    n = 0;
    while (grant_q.size() < 8 && n < 100) begin step(); n++; end
    req_mode = 0;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    n = 0;
    while ((m_busy || m_rsp_valid != '0) && n < 50) begin step(); n++; end
    chk("t3_grants", 32'(grant_q.size()), 32'd8);
    if (grant_q.size() >= 8) begin
      for (int i = 0; i < 8; i++) chk("t3_order", 32'(grant_q[i]), 32'(i % 4));
      chk("t3_b2b_span", 32'(grant_cyc[7] - grant_cyc[0]), 32'd14);
    end

    // slave error on a read, then a normal write
    reset_dut(); clr_obs();
    slv_wait = 1; slv_err = 1'b1; slv_rdata = 32'hCAFE0001;
    set_req(1, 1'b0, 8'h20, 32'h0);
    run_until_rsp("t4a", 20);
    chk("t4a_slverr", 32'(seen_err), 32'd1);
    chk("t4a_rdata", seen_rdata, 32'hCAFE0001);
    chk("t4a_rsp_mask", 32'(seen_mask), 32'h2);
    clr_obs();
    slv_err = 1'b0;
    set_req(3, 1'b1, 8'h30, 32'h0BADF00D);
    run_until_rsp("t4b", 20);
    chk("t4b_slverr", 32'(seen_err), 32'd0);
    chk("t4b_rdata", seen_rdata, 32'h0);
    chk("t4b_rsp_mask", 32'(seen_mask), 32'h8);

    // timeout
    reset_dut(); clr_obs();
    slv_mode = 2; slv_rdata = 32'hFFFFFFFF;
    set_req(0, 1'b0, 8'h55, 32'h0);
    run_until_rsp("t5", 40);
    chk("t5_penable_cycles", 32'(n_pen), 32'd16);
    chk("t5_psel_cycles", 32'(n_psel), 32'd17);
    chk("t5_slverr", 32'(seen_err), 32'd1);
    chk("t5_rdata", seen_rdata, 32'h0);
    chk("t5_rsp_mask", 32'(seen_mask), 32'h1);

    // reset in the middle of a waited read
    reset_dut(); clr_obs();
    set_req(1, 1'b0, 8'h66, 32'h0);
    repeat (6) step();
    rst_drv = 1'b0;
    pend_v[1] = 1'b0;
    step();
    rst_drv = 1'b1;
    clr_obs();
    repeat (3) step();
    chk("t6_psel_after_rst", 32'(n_psel), 32'd0);
    chk("t6_no_rsp", 32'(seen_mask), 32'h0);
    slv_mode = 0; slv_wait = 0; slv_rdata = 32'hA5A5A5A5;
    set_req(0, 1'b0, 8'h01, 32'h0);
    set_req(3, 1'b0, 8'h03, 32'h0);
    run_until_rsp("t6", 20);
    chk("t6_first_grant", 32'(grant_q.size() > 0 ? grant_q[0] : -1), 32'd0);
    chk("t6_rsp_mask", 32'(seen_mask), 32'h1);
    n = 0;
    while ((m_busy || m_rsp_valid != '0 || pend_v[3]) && n < 50) begin step(); n++; end

    // randomized traffic
    reset_dut(); clr_obs();
    req_mode = 2; slv_mode = 1;
    repeat (3000) step();
    chk("rand_activity", 32'(grant_q.size() > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares the single APB master port (8-bit address, 32-bit data) among NUM_REQ local requesters.
- Arbitration is round-robin.
- Sequences each granted request through the APB SETUP and ACCESS phases, waits for pready, then returns read data and error status to the winning requester.
- Sits between the register-access clients and the APB slave bus. Its bus-side outputs must satisfy the team's APB protocol assertions: psel stable, penable after psel, addr/wdata stable, penable only with psel, penable deasserted after transfer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 16, maximum consecutive ACCESS cycles with pready low before forced termination; 0 disables the timeout

Ports:
pclk  in  1  APB clock; all logic on rising edge
preset_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept strobe (one-hot or zero)
req_write  in  NUM_REQ  per-requester direction: 1 = write
req_addr  in  NUM_REQ*8  per-requester address, requester i at [8i+7:8i]
req_wdata  in  NUM_REQ*32  per-requester write data, requester i at [32i+31:32i]
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
rsp_rdata  out  32  read data; 0 for writes and timeouts
rsp_slverr  out  1  pslverr captured at completion, or 1 on timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  8  APB address
pwdata  out  32  APB write data
prdata  in  32  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset (preset_n low at an edge): state IDLE; all outputs 0; round-robin pointer last_grant = NUM_REQ-1, so requester 0 has top priority first.
- Reset mid-transfer aborts it: psel/penable drop at that edge, and no rsp_valid is issued for the dropped request.
- FSM states: IDLE, SETUP, ACCESS.
- Arbitration:
  - Runs combinationally whenever state is IDLE, or state is ACCESS with pready=1.
  - Winner is the first asserted req_valid searching from last_grant+1 upward, with wrap-around.
  - req_ready[winner]=1 in that cycle only. The handshake is req_valid & req_ready.
- On accept: latch write/addr/wdata into pwrite/paddr/pwdata; store owner index; last_grant <= winner; next state SETUP (psel=1, penable=0).
- SETUP -> ACCESS unconditionally after one cycle (penable=1).
- ACCESS with pready=1 at an edge:
  - Registered rsp_valid[owner]=1 for one cycle.
  - rsp_rdata = write ? 0 : prdata; rsp_slverr = pslverr.
  - If another request was accepted in the same cycle, go to SETUP: psel stays 1, penable drops, bus fields take the new values (back-to-back).
  - Otherwise go to IDLE: psel=0, penable=0.
- ACCESS with pready=0: hold every bus output stable; timeout counter increments.
  - Counter clears on entering SETUP.
  - When TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES: complete as above with rsp_slverr=1 and rsp_rdata=0, and go to IDLE without arbitrating that cycle.
- Latency: request accepted at edge E0 -> psel high after E0 -> penable high after E1 -> earliest pready sampled at E2 -> rsp_valid high E2..E3. Minimum turnaround is 3 cycles per request; sustained back-to-back is 2 cycles per transfer.
- req_ready is never asserted in SETUP or in ACCESS with pready=0.
- The requester must hold req_* stable while req_valid=1 and not yet accepted.
- pwdata/paddr/pwrite change only on accept edges; when idle they hold their last values.
- Simultaneous requests: exactly one is granted per arbitration cycle; the others remain pending.
- A requester whose req_valid drops before acceptance is simply skipped; no penalty.

Test Plan:
- Single write: req0 write addr 0x10 data 0xDEADBEEF, slave pready=1 immediately -> psel 2 cycles, penable 1 cycle, paddr=0x10, rsp_valid[0] one pulse, rsp_slverr=0.
- Single read with 3 wait states: req2 read 0x44, prdata=0x12345678 on the pready cycle -> penable held 4 cycles, all bus outputs stable throughout, rsp_rdata=0x12345678, rsp_valid[2] only.
- Round-robin: all 4 req_valid held high for 8 transfers, zero-wait slave -> grant order 0,1,2,3,0,1,2,3; back-to-back SETUP with no IDLE gap; all protocol assertions pass.
- Slave error: read with pslverr=1 at the pready cycle -> rsp_slverr=1 and rsp_rdata=prdata, next grant proceeds normally.
- Timeout: pready held 0, TIMEOUT_CYCLES=16 -> 16 ACCESS cycles, then psel/penable drop, rsp_slverr=1, rsp_rdata=0. The bench disables the psel-stability assertion for this test only.
- Reset mid-ACCESS: preset_n low for 1 cycle during a waited read -> all outputs 0 the next cycle, no rsp_valid; req0 wins the first grant after reset.
